// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial adder/subtractor, DIGIT bits per cycle through one
// adder slice with a registered carry, valid/ready handshakes on both sides.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   y,
    output logic             ovf,
    output logic             zero
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] opa, opb, res, res_nx;
    logic [CW-1:0] cnt;
    logic carry, mode, msb_cin;
    logic [DIGIT:0] dsum;
    assign dsum = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign res_nx = WIDTH'({dsum[DIGIT-1:0], res} >> DIGIT);
    // carry into the top bit of the digit, recovered from its sum bit and operand bits
    assign msb_cin = dsum[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
    assign in_ready = en && (state == IDLE || (state == DONE && out_ready));
    assign out_valid = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opa <= '0;
            opb <= '0;
            res <= '0;
            cnt <= '0;
            carry <= 1'b0;
            mode <= 1'b0;
            y <= '0;
            ovf <= 1'b0;
            zero <= 1'b0;
        end else if (en) begin
            if (state == RUN) begin
                opa <= opa >> DIGIT;
                opb <= opb >> DIGIT;
                res <= res_nx;
                carry <= dsum[DIGIT];
                cnt <= cnt + CW'(1);
                if (cnt == LAST) begin
                    state <= DONE;
                    y <= {dsum[DIGIT] ^ mode, res_nx};
                    ovf <= msb_cin ^ dsum[DIGIT];
                    zero <= res_nx == '0;
                end
            end else if (in_valid && in_ready) begin
                opa <= a;
                opb <= b ^ {WIDTH{sub}};
                carry <= sub;
                mode <= sub;
                cnt <= '0;
                state <= RUN;
            end else if (state == DONE && out_ready) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed vectors and corner sequences on a 16/4 instance, plus
// randomized back-to-back traffic on every WIDTH/DIGIT combination against a signed/unsigned model.
module tb_addsub_serial;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, grst_n, en, in_valid, in_ready, sub, out_valid, out_ready, ovf, zero;
    logic [15:0] a, b;
    logic [16:0] y;
    int checks = 0;
    int errors = 0;
    bit gdone [12];

    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf), .zero(zero)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar i = 0; i < 3; i++) begin : g_w
        for (genvar j = 0; j < 4; j++) begin : g_d
            localparam int W = 8 << i;
            localparam int D = 1 << j;
            logic [W-1:0] ga, gb;
            logic [W:0] gy;
            logic gs, gvld, gir, gov, gro, govf, gz;
            addsub_serial #(.WIDTH(W), .DIGIT(D)) u (
                .clk(clk), .rst_n(grst_n), .en(1'b1), .in_valid(gvld), .in_ready(gir),
                .a(ga), .b(gb), .sub(gs), .out_valid(gov), .out_ready(gro),
                .y(gy), .ovf(govf), .zero(gz)
            );
            initial begin
                longint ua, ub, sa, sb, sr, h;
                logic [W:0] ey;
                logic eo;
                int n;
                string tag;
                tag = $sformatf("W%0d_D%0d", W, D);
                gvld = 1'b0;
                gro = 1'b0;
                ga = '0;
                gb = '0;
                gs = 1'b0;
                wait (grst_n);
                @(negedge clk);
                for (int k = 0; k < 25; k++) begin
                    ga = (k % 4 == 0) ? W'(1) << (W - 1) : W'($urandom);
                    gb = (k % 3 == 0) ? {W{1'b1}} : W'($urandom);
                    if (k % 7 == 0) gb = ga;
                    gs = 1'($urandom);
                    h = longint'(1) << W;
                    ua = longint'(ga);
                    ub = longint'(gb);
                    sa = ga[W-1] ? ua - h : ua;
                    sb = gb[W-1] ? ub - h : ub;
                    if (gs) begin
                        ey[W-1:0] = W'(ua - ub);
                        ey[W] = ua < ub;
                        sr = sa - sb;
                    end else begin
                        ey = (W + 1)'(ua + ub);
                        sr = sa + sb;
                    end
                    eo = sr >= h / 2 || sr < -(h / 2);
                    gvld = 1'b1;
                    n = 0;
                    while (!gir && n < 100) begin @(negedge clk); n++; end
                    chk({tag, "_accept"}, gir, 1);
                    @(negedge clk);
                    gvld = 1'b0;
                    gro = 1'b0;
                    ga = W'($urandom);
                    n = 0;
                    while (!gov && n < 100) begin @(negedge clk); n++; end
                    chk({tag, "_lat"}, n, W / D);
                    chk({tag, "_y"}, gy, ey);
                    chk({tag, "_ovf"}, govf, eo);
                    chk({tag, "_zero"}, gz, ey[W-1:0] == '0);
                    repeat ($urandom_range(0, 2)) begin
                        @(negedge clk);
                        chk({tag, "_hold"}, {gov, gy}, {1'b1, ey});
                    end
                    gro = 1'b1;
                end
                @(negedge clk);
                gro = 1'b0;
                gdone[i*4+j] = 1'b1;
            end
        end
    end

    typedef struct {
        logic [15:0] a, b;
        logic sub;
        logic [16:0] y;
        logic ovf, zero;
    } vec_t;
    vec_t tv [8];

    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vs, output int lat);
        int n = 0;
        a = va;
        b = vb;
        sub = vs;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        sub = ~vs;
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat, n, nd;
        tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0, 1'b1};
        tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1, 1'b0};
        tv[2] = '{16'h0005, 16'h0007, 1'b1, 17'h1FFFE, 1'b0, 1'b0};
        tv[3] = '{16'h8000, 16'h0001, 1'b1, 17'h07FFF, 1'b1, 1'b0};
        tv[4] = '{16'h1234, 16'h1234, 1'b1, 17'h00000, 1'b0, 1'b1};
        tv[5] = '{16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1, 1'b1};
        tv[6] = '{16'h0000, 16'h0000, 1'b1, 17'h00000, 1'b0, 1'b1};
        tv[7] = '{16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0, 1'b0};
        rst_n = 1'b0;
        grst_n = 1'b0;
        en = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", {out_valid, in_ready, y, ovf, zero}, {1'b0, 1'b1, 17'h0, 1'b0, 1'b0});
        rst_n = 1'b1;
        grst_n = 1'b1;
        @(negedge clk);
        foreach (tv[k]) begin
            run_op(tv[k].a, tv[k].b, tv[k].sub, lat);
            chk($sformatf("v%0d_lat", k), lat, 4);
            chk($sformatf("v%0d_y", k), y, tv[k].y);
            chk($sformatf("v%0d_ovf", k), ovf, tv[k].ovf);
            chk($sformatf("v%0d_zero", k), zero, tv[k].zero);
            release_out();
        end
        chk("idle_hold", {out_valid, y, ovf, zero}, {1'b0, 17'h05555, 1'b0, 1'b0});
        // backpressure then release-and-accept on the same edge
        run_op(16'h1111, 16'h2222, 1'b0, lat);
        chk("bp_lat", lat, 4);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", {out_valid, in_ready, y, ovf, zero}, {1'b1, 1'b0, 17'h03333, 1'b0, 1'b0});
        end
        out_ready = 1'b1;
        #1 chk("bp_ready", in_ready, 1);
        run_op(16'h00FF, 16'h0F00, 1'b1, lat);
        chk("b2b_lat", lat, 4);
        chk("b2b_y", {y, ovf, zero}, {17'h1F1FF, 1'b0, 1'b0});
        release_out();
        // stall two cycles at cnt=2
        a = 16'hABCD;
        b = 16'h1111;
        sub = 1'b0;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'h0;
        repeat (2) @(negedge clk);
        en = 1'b0;
        #1 chk("stall_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        en = 1'b1;
        lat = 4;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        chk("stall_lat", lat, 6);
        chk("stall_y", {y, ovf, zero}, {17'h0BCDE, 1'b0, 1'b0});
        en = 1'b0;
        out_ready = 1'b1;
        #1 chk("en0_ready", in_ready, 0);
        @(negedge clk);
        chk("en0_done_hold", out_valid, 1);
        en = 1'b1;
        @(negedge clk);
        chk("en1_release", out_valid, 0);
        out_ready = 1'b0;
        // reset at cnt=1 aborts the operation
        a = 16'h7777;
        b = 16'h1234;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("midrst", {out_valid, in_ready, y, ovf, zero}, {1'b0, 1'b1, 17'h0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0F0F, 16'h0101, 1'b0, lat);
        chk("postrst_lat", lat, 4);
        chk("postrst_y", {y, ovf, zero}, {17'h01010, 1'b0, 1'b0});
        release_out();
        n = 0;
        do begin
            nd = 0;
            foreach (gdone[k]) nd += int'(gdone[k]);
            if (nd < 12) @(negedge clk);
            n++;
        end while (nd < 12 && n < 20000);
        chk("gen_done", nd, 12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
